// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller and its hazard unit.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction reading the destination of a load in EX.
module hazard_detect #(
  parameter int unsigned NB_addr = 5
) (
  input  logic               ex_mem_read,
  input  logic [NB_addr-1:0] ex_rt,
  input  logic [NB_addr-1:0] id_rs,
  input  logic [NB_addr-1:0] id_rt,
  input  logic               id_uses_rt,
  output logic               hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = ex_mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flushes and the debug run/step/halt FSM.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_addr      = 5,
  parameter int unsigned NB_cnt       = 32,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NB_addr-1:0] in_id_rs,
  input  logic [NB_addr-1:0] in_id_rt,
  input  logic              in_id_uses_rt,
  input  logic              in_ex_mem_read,
  input  logic [NB_addr-1:0] in_ex_rt,
  input  logic              in_branch_taken,
  input  logic              in_halt_instr,
  input  logic              in_dbg_run,
  input  logic              in_dbg_step,
  output logic              out_stage_en,
  output logic              out_pc_write,
  output logic              out_if_id_write,
  output logic              out_id_ex_bubble,
  output logic              out_if_id_flush,
  output logic              out_halted,
  output logic [NB_cnt-1:0] out_cycle_count
);

  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t              state, state_next;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic [NB_cnt-1:0]   cycle_cnt;
  logic                hazard;
  logic                advance;
  logic                drain_load;

  hazard_detect #(
    .NB_addr(NB_addr)
  ) u_hazard_detect (
    .ex_mem_read(in_ex_mem_read),
    .ex_rt      (in_ex_rt),
    .id_rs      (in_id_rs),
    .id_rt      (in_id_rt),
    .id_uses_rt (in_id_uses_rt),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    advance          = 1'b0;
    drain_load       = 1'b0;
    out_pc_write     = 1'b0;
    out_if_id_write  = 1'b0;
    out_id_ex_bubble = 1'b0;
    out_if_id_flush  = 1'b0;
    out_halted       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_dbg_run) begin
          state_next = ST_RUN;
        end else if (in_dbg_step) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        advance = 1'b1;
        // A step retires to IDLE whatever happened, unless HALT hands off to DRAIN.
        state_next = (state == ST_STEP) ? ST_IDLE : ST_RUN;
        if (hazard) begin
          out_id_ex_bubble = 1'b1;
        end else if (in_halt_instr) begin
          out_id_ex_bubble = 1'b1;
          drain_load       = 1'b1;
          state_next       = ST_DRAIN;
        end else begin
          out_pc_write    = 1'b1;
          out_if_id_write = 1'b1;
          out_if_id_flush = in_branch_taken;
        end
      end
      ST_DRAIN: begin
        advance          = 1'b1;
        out_id_ex_bubble = 1'b1;
        if (drain_cnt == '0) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        out_halted = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    out_stage_en = advance;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (drain_load) begin
      drain_cnt <= NB_DRAIN'(DRAIN_CYCLES - 1);
    end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - NB_DRAIN'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (advance && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + NB_cnt'(1);
    end
  end

  assign out_cycle_count = cycle_cnt;

endmodule
